prime_checker: RTL and testbench
================================

// Module: prime_checker
// PURPOSE
//  Downstream of the push-button random number generator. Captures its WIDTH-bit
//  output on a start pulse and decides by trial division whether the value is prime.
//  Remainders come from repeated subtraction, so the block is multi-cycle.
//  Drives busy/done/is_prime to the display and guess-compare logic.
// PARAMETERS
//  WIDTH    4   bit width of the number under test (num_in, internal n/r/d)
//  CNT_W    8   width of cycle_cnt (only with PRIME_CYCLE_CNT_EN)
// PORTS
//  clk        in   1        single clock, all logic on posedge clk
//  rst        in   1        synchronous reset, active-high
//  start      in   1        request; sampled only in IDLE
//  num_in     in   WIDTH    number to test (generator gen_out)
//  busy       out  1        high in every non-IDLE state
//  done       out  1        one-cycle pulse, result valid
//  is_prime   out  1        result; held from done until next accepted start
//  num_out    out  WIDTH    copy of the captured number, held with is_prime
//  cycle_cnt  out  CNT_W    [PRIME_CYCLE_CNT_EN only] cycles from capture to done
// BEHAVIOUR
//  - rst=1 at a clock edge: state=IDLE; busy=0, done=0, is_prime=0, num_out=0,
//    cycle_cnt=0. Reset has priority over everything and aborts any test in progress.
//  - Internal regs: n (WIDTH), d (WIDTH, divisor), r (WIDTH, remainder).
//  - IDLE:  start=1 -> n=num_in, num_out=num_in, d=2, is_prime=0, go TEST.
//           start=0 -> stay; outputs hold.
//  - TEST:  n<2 -> result 0, go DONE.
//           d*d>n (computed at 2*WIDTH bits, no overflow) -> result 1, go DONE.
//           otherwise r=n, go SUB.
//  - SUB:   checks are evaluated in this order:
//           r==0 -> result 0, go DONE.
//           r<d  -> d=d+1, go TEST.
//           else -> r=r-d, stay in SUB.
//  - DONE:  done=1 for this cycle only; is_prime=result; go IDLE.
//           is_prime and num_out hold until the next accepted start.
//  - Latency: for n in {0,1,2,3}, done is high in the 2nd cycle after the start
//    edge. Larger n takes longer, with worst-case latency bounded by sum(n/d + 2).
//  - start is ignored while busy=1 and during the DONE cycle. There is no queuing.
//  - num_in is sampled only at the capture edge. Later changes have no effect.
//  - d never exceeds 2^(WIDTH/2)+1, so it does not wrap for WIDTH>=2.
// CONFIGURATION
//  PRIME_CYCLE_CNT_EN defined:
//    - cycle_cnt port exists. It is cleared at capture and increments every busy cycle.
//    - It saturates at 2^CNT_W-1 and is held after done until the next capture.
//  PRIME_CYCLE_CNT_EN undefined:
//    - cycle_cnt port and its counter are absent.
//    - All other behaviour is identical.
// STRUCTURE
//  - prime_pkg: state encoding (IDLE, TEST, SUB, DONE as localparams), default WIDTH.
//  - No sub-module. The FSM plus compare/subtract datapath stay inline in one file.
// TESTING
//  1. rst=1 mid-SUB (num_in=15) -> next cycle busy=0, done=0, is_prime=0, num_out=0.
//  2. start with num_in=0, then 1 -> done in the 2nd cycle after start, is_prime=0,
//     num_out matches the input.
//  3. start with num_in=2, then 3 -> done in the 2nd cycle after start, is_prime=1.
//  4. Sweep num_in=0..15 -> is_prime=1 exactly for 2,3,5,7,11,13.
//     Check 9 (d=3 square case) -> 0 and 15 -> 0.
//  5. start held high and num_in changed while busy -> no recapture.
//     done pulses once, and num_out keeps the first value.
//  6. [PRIME_CYCLE_CNT_EN] num_in=13 -> cycle_cnt equals the number of busy cycles
//     counted by the bench. With CNT_W=2, cycle_cnt saturates at 3.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared definitions for the prime checker: default operand width and FSM state encoding.
package prime_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StTest = 2'd1;
    localparam state_t StSub  = 2'd2;
    localparam state_t StDone = 2'd3;

endpackage

// File: rtl/prime_checker.sv
// Multi-cycle trial-division primality tester; remainders come from repeated subtraction.
// Optional busy-cycle counter on cycle_cnt is enabled by defining PRIME_CYCLE_CNT_EN.
module prime_checker
    import prime_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
`ifdef PRIME_CYCLE_CNT_EN
    ,
    parameter int unsigned CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num_in,
    output logic             busy,
    output logic             done,
    output logic             is_prime,
    output logic [WIDTH-1:0] num_out
`ifdef PRIME_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt
`endif
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   n_q, n_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic               prime_q, prime_d;
    logic [WIDTH-1:0]   num_out_q, num_out_d;
    logic [2*WIDTH-1:0] d_sq;
    logic [2*WIDTH-1:0] n_ext;
    logic               capture;

    // Square at double width so the d*d > n test cannot overflow.
    assign d_sq    = {{WIDTH{1'b0}}, d_q} * {{WIDTH{1'b0}}, d_q};
    assign n_ext   = {{WIDTH{1'b0}}, n_q};
    assign capture = (state_q == StIdle) && start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            n_q       <= '0;
            d_q       <= '0;
            r_q       <= '0;
            prime_q   <= 1'b0;
            num_out_q <= '0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            d_q       <= d_d;
            r_q       <= r_d;
            prime_q   <= prime_d;
            num_out_q <= num_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        d_d       = d_q;
        r_d       = r_q;
        prime_d   = prime_q;
        num_out_d = num_out_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    n_d       = num_in;
                    num_out_d = num_in;
                    d_d       = WIDTH'(2);
                    prime_d   = 1'b0;
                    state_d   = StTest;
                end
            end
            StTest: begin
                if (n_q < WIDTH'(2)) begin
                    prime_d = 1'b0;
                    state_d = StDone;
                end else if (d_sq > n_ext) begin
                    prime_d = 1'b1;
                    state_d = StDone;
                end else begin
                    r_d     = n_q;
                    state_d = StSub;
                end
            end
            StSub: begin
                if (r_q == '0) begin
                    prime_d = 1'b0;
                    state_d = StDone;
                end else if (r_q < d_q) begin
                    d_d     = d_q + WIDTH'(1);
                    state_d = StTest;
                end else begin
                    r_d = r_q - d_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle);
        done     = (state_q == StDone);
        is_prime = prime_q;
        num_out  = num_out_q;
    end

`ifdef PRIME_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Saturating count of busy cycles; cleared on capture, frozen while idle.
    always_comb begin
        cnt_d = cnt_q;
        if (capture) begin
            cnt_d = '0;
        end else if (busy && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign cycle_cnt = cnt_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_prime_checker.sv
// Self-checking bench for prime_checker: directed scenarios plus random operands vs. a model.
module tb_prime_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] num_in;
    logic       busy;
    logic       done;
    logic       is_prime;
    logic [3:0] num_out;
`ifdef PRIME_CYCLE_CNT_EN
    logic [7:0] cycle_cnt;
    logic       sat_busy, sat_done, sat_is_prime;
    logic [3:0] sat_num_out;
    logic [1:0] sat_cycle_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prime_checker #(
        .WIDTH(4)
`ifdef PRIME_CYCLE_CNT_EN
        ,
        .CNT_W(8)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_in   (num_in),
        .busy     (busy),
        .done     (done),
        .is_prime (is_prime),
        .num_out  (num_out)
`ifdef PRIME_CYCLE_CNT_EN
        ,
        .cycle_cnt(cycle_cnt)
`endif
    );

`ifdef PRIME_CYCLE_CNT_EN
    prime_checker #(
        .WIDTH(4),
        .CNT_W(2)
    ) dut_sat (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_in   (num_in),
        .busy     (sat_busy),
        .done     (sat_done),
        .is_prime (sat_is_prime),
        .num_out  (sat_num_out),
        .cycle_cnt(sat_cycle_cnt)
    );
`endif

    function automatic logic ref_prime(input int n);
        if (n < 2) return 1'b0;
        for (int i = 2; i < n; i++) begin
            if (n % i == 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full transaction; checks result, hold values and single done pulse.
    task automatic run_test(input logic [3:0] v, output int lat, output logic res);
        int busy_cycles;
        @(negedge clk);
        start  = 1'b1;
        num_in = v;
        @(negedge clk);
        start  = 1'b0;
        num_in = 4'($urandom);
        lat = 1;
        busy_cycles = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cycles++;
        end
        if (!done) chk($sformatf("timeout n=%0d", v), 32'(done), 32'd1);
        res = is_prime;
        chk($sformatf("is_prime n=%0d", v), 32'(is_prime), 32'(ref_prime(int'(v))));
        chk($sformatf("num_out n=%0d", v), 32'(num_out), 32'(v));
        @(negedge clk);
        chk($sformatf("done_pulse n=%0d", v), 32'(done), 32'd0);
        chk($sformatf("idle n=%0d", v), 32'(busy), 32'd0);
        chk($sformatf("hold n=%0d", v), 32'(is_prime), 32'(ref_prime(int'(v))));
`ifdef PRIME_CYCLE_CNT_EN
        chk($sformatf("cycle_cnt n=%0d", v), 32'(cycle_cnt), 32'(busy_cycles));
        chk($sformatf("sat_cnt n=%0d", v), 32'(sat_cycle_cnt),
            32'(busy_cycles > 3 ? 3 : busy_cycles));
`endif
    endtask

    initial begin
        int         lat;
        int         pulses;
        logic       res;
        logic [3:0] v;

        rst    = 1'b1;
        start  = 1'b0;
        num_in = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_prime", 32'(is_prime), 32'd0);
        chk("rst_num_out", 32'(num_out), 32'd0);
        rst = 1'b0;

        // Small operands finish in the 2nd cycle after the start edge.
        for (int i = 0; i < 4; i++) begin
            run_test(4'(i), lat, res);
            chk($sformatf("latency n=%0d", i), 32'(lat), 32'd2);
        end

        // Reset mid-SUB must abort and clear everything, including a prior prime result.
        run_test(4'd7, lat, res);
        @(negedge clk);
        start  = 1'b1;
        num_in = 4'd15;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_prime", 32'(is_prime), 32'd0);
        chk("abort_num_out", 32'(num_out), 32'd0);
`ifdef PRIME_CYCLE_CNT_EN
        chk("abort_cnt", 32'(cycle_cnt), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            run_test(4'(i), lat, res);
            if (i == 9) chk("square_9", 32'(res), 32'd0);
            if (i == 15) chk("comp_15", 32'(res), 32'd0);
            if (i == 13) chk("prime_13", 32'(res), 32'd1);
        end

        // start held high and num_in changed while busy: no recapture.
        @(negedge clk);
        start  = 1'b1;
        num_in = 4'd13;
        @(negedge clk);
        num_in = 4'd4;
        lat    = 1;
        pulses = 0;
        while (!done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (done) pulses++;
        start = 1'b0;
        chk("hold_num_out", 32'(num_out), 32'd13);
        chk("hold_prime", 32'(is_prime), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("single_pulse", 32'(pulses), 32'd1);
        chk("hold_after", 32'(num_out), 32'd13);

        repeat (20) begin
            v = 4'($urandom_range(0, 15));
            run_test(v, lat, res);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
